branch_rs: RTL and testbench
============================

Name: branch_rs

Overview:
- Branch reservation station for the out-of-order RV32I core; sits directly upstream of the branch comparator in the execution stage.
- Holds dispatched conditional branches until both source operands are available, capturing them from the common data bus (CDB).
- Issues the oldest ready branch (funct3 as cmpop, operands a/b, pc, imm, ROB tag, prediction) to the compare/resolve stage over a valid/ready handshake.

Parameters:
- DEPTH, 4, number of entries (≥2).
- TAG_W, 4, ROB/physical tag width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  mispredict/exception flush; clears all entries.
- dispatch_valid  in  1  new branch offered.
- dispatch_ready  out  1  station can accept this cycle.
- dispatch_funct3  in  3  branch_funct3_t (beq..bgeu).
- dispatch_rob_tag  in  TAG_W  ROB tag of the branch.
- dispatch_pc  in  32  branch PC.
- dispatch_imm  in  32  sign-extended B-immediate.
- dispatch_pred_taken  in  1  front-end prediction.
- dispatch_rs1_rdy / dispatch_rs2_rdy  in  1 each  operand value already valid.
- dispatch_rs1_val / dispatch_rs2_val  in  32 each  operand value (used if rdy).
- dispatch_rs1_tag / dispatch_rs2_tag  in  TAG_W each  producer tag (used if !rdy).
- cdb_valid  in  1  CDB broadcast valid.
- cdb_tag  in  TAG_W  broadcast tag.
- cdb_data  in  32  broadcast value.
- issue_valid  out  1  issue_* fields valid.
- issue_ready  in  1  compare stage accepts.
- issue_cmpop  out  3  branch_funct3_t to comparator.
- issue_a / issue_b  out  32 each  rs1 / rs2 values.
- issue_pc / issue_imm  out  32 each  for target computation downstream.
- issue_rob_tag  out  TAG_W.
- issue_pred_taken  out  1.

Behaviour:
- Reset (rst=0, async): all entry valid bits 0, count 0; so issue_valid=0, dispatch_ready=1. Payload registers need not reset; issue_* data outputs are don't-care while issue_valid=0.
- Storage: collapsing queue; slot 0 oldest. Entry = valid, funct3, rob_tag, pc, imm, pred, {rdy,tag,val} per operand.
- dispatch_ready = (count != DEPTH) && !flush; registered count only, no same-cycle issue credit. Dispatch fires on dispatch_valid && dispatch_ready; entry written to slot count (or count-1 if an issue fires that cycle).
- CDB capture: every valid entry with !rdy and tag==cdb_tag on cdb_valid sets rdy=1, val=cdb_data at the edge; both operands may capture from one broadcast.
- Dispatch/CDB bypass: if dispatching operand has !rdy and matches the same-cycle CDB tag, it is written as ready with cdb_data.
- Select: issue_valid = !flush && any entry with both operands rdy; chosen entry = lowest-index such entry; issue_* driven combinationally from it.
- Wakeup is not forwarded to select: an operand captured at edge t is issuable from cycle t+1. A branch dispatched with both operands ready at edge t presents issue_valid in cycle t+1 (minimum 1-cycle latency).
- Issue fires on issue_valid && issue_ready; the entry is removed at the edge and all higher entries shift down one slot, preserving age. Held entry fields stay stable while issue_ready=0.
- Simultaneous dispatch + issue: both occur; count unchanged; new entry lands after the shift.
- Simultaneous CDB + issue: shifted entries still capture correctly; capture is applied to the post-shift slot.
- flush=1: issue_valid=0 and dispatch_ready=0 that cycle; all valid bits clear at the edge; CDB ignored.
- Full (count==DEPTH): dispatch_ready=0 even if an issue fires the same cycle.
- Empty: issue_valid=0.

Decomposition:
- Shared rv32i_types package: branch_funct3_t (already present); add rs_operand_t struct {rdy, tag, val} and brs_entry_t struct.
- TAG_W default is taken from the package ROB tag width constant.
- Sub-module: rs_operand_capture (one operand's CDB-match/bypass logic), instantiated 2×DEPTH plus 2 for the dispatch path.

Test Plan:
- Reset mid-operation with 3 entries held -> next cycle issue_valid=0, dispatch_ready=1, count 0.
- Dispatch beq, rs1=5, rs2=5, both ready -> issue_valid=1 next cycle with issue_a=5, issue_b=5, issue_cmpop=beq.
- Dispatch blt, rs1 ready=−1, rs2 waiting tag 3; issue_ready=1; CDB tag 3 data 7 at cycle 2 -> issue_valid rises in cycle 3 with issue_b=7, not earlier.
- Dispatch and CDB broadcast of tag 9 (data 0x100) in the same cycle, where the dispatched rs1 waits on tag 9 -> entry is stored ready; issue_a=0x100 next cycle.
- Fill 4 entries; only slot 2 ready; issue_ready held 0 for 3 cycles -> slot 2 fields stable; dispatch_ready=0. Raise issue_ready -> slot 2 issues, old slot 3 moves to slot 2, dispatch_ready=1 next cycle.
- Two entries ready (ROB tags 4 then 6) plus flush asserted -> issue_valid=0 that cycle, station empty next cycle. Without flush -> tag 4 issues before tag 6.

Source files
------------

// File: rtl/rv32i_types.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_types (package)
// Description : Shared RV32I core types. Holds the branch funct3 encoding,
//               the ROB tag width and the reservation-station operand and
//               branch entry records.
// Revision    : 1.0 - initial release
// ============================================================================
package rv32i_types;

   // ROB / physical tag width shared by all reservation stations.
   localparam int c_ROB_TAG_W = 4;

   // Conditional branch compare operations (RV32I funct3 encoding).
   typedef enum logic [2:0] {
      BEQ  = 3'b000,
      BNE  = 3'b001,
      BLT  = 3'b100,
      BGE  = 3'b101,
      BLTU = 3'b110,
      BGEU = 3'b111
   } branch_funct3_t;

   // One source operand: either a value (rdy=1) or a producer tag (rdy=0).
   typedef struct packed {
      logic                   rdy;
      logic [c_ROB_TAG_W-1:0] tag;
      logic [31:0]            val;
   } rs_operand_t;

   // One branch reservation-station entry.
   typedef struct packed {
      logic                   valid;
      branch_funct3_t         funct3;
      logic [c_ROB_TAG_W-1:0] rob_tag;
      logic [31:0]            pc;
      logic [31:0]            imm;
      logic                   pred_taken;
      rs_operand_t            rs1;
      rs_operand_t            rs2;
   } brs_entry_t;

endpackage : rv32i_types
`default_nettype wire

// File: rtl/rs_operand_capture.sv
`default_nettype none
// ============================================================================
// Module      : rs_operand_capture
// Description : Common-data-bus snoop for a single reservation-station
//               operand. A waiting operand whose producer tag matches a valid
//               broadcast is returned as ready carrying the broadcast value;
//               otherwise the operand passes through unchanged.
// Ports       : op_in      - operand as currently held / being dispatched
//               cdb_valid  - broadcast valid
//               cdb_tag    - broadcast producer tag
//               cdb_data   - broadcast value
//               op_out     - operand after capture
// Revision    : 1.0 - initial release
// ============================================================================
module rs_operand_capture
   import rv32i_types::*;
(
   input  rs_operand_t            op_in,
   input  logic                   cdb_valid,
   input  logic [c_ROB_TAG_W-1:0] cdb_tag,
   input  logic [31:0]            cdb_data,
   output rs_operand_t            op_out
);

   logic w_hit;

   // Already-ready operands never capture, even if a stale tag matches.
   assign w_hit = cdb_valid && !op_in.rdy && (op_in.tag == cdb_tag);

   always_comb begin
      op_out = op_in;
      if (w_hit) begin
         op_out.rdy = 1'b1;
         op_out.val = cdb_data;
      end
   end

endmodule : rs_operand_capture
`default_nettype wire

// File: rtl/branch_rs.sv
`default_nettype none
// ============================================================================
// Module      : branch_rs
// Description : Branch reservation station. Collapsing age-ordered queue
//               (slot 0 oldest) that holds dispatched conditional branches
//               until both operands are ready, snooping the CDB, and issues
//               the oldest ready branch over a valid/ready handshake.
// Ports       : clk, rst (async, active low), flush
//               dispatch_* - new branch in (valid/ready handshake)
//               cdb_*      - common data bus broadcast
//               issue_*    - oldest ready branch out (valid/ready handshake)
// Revision    : 1.0 - initial release
// ============================================================================
module branch_rs
   import rv32i_types::*;
#(
   parameter int DEPTH = 4,
   // Must match c_ROB_TAG_W: entries store tags in the shared record layout.
   parameter int TAG_W = c_ROB_TAG_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,

   input  logic             dispatch_valid,
   output logic             dispatch_ready,
   input  branch_funct3_t   dispatch_funct3,
   input  logic [TAG_W-1:0] dispatch_rob_tag,
   input  logic [31:0]      dispatch_pc,
   input  logic [31:0]      dispatch_imm,
   input  logic             dispatch_pred_taken,
   input  logic             dispatch_rs1_rdy,
   input  logic             dispatch_rs2_rdy,
   input  logic [31:0]      dispatch_rs1_val,
   input  logic [31:0]      dispatch_rs2_val,
   input  logic [TAG_W-1:0] dispatch_rs1_tag,
   input  logic [TAG_W-1:0] dispatch_rs2_tag,

   input  logic             cdb_valid,
   input  logic [TAG_W-1:0] cdb_tag,
   input  logic [31:0]      cdb_data,

   output logic             issue_valid,
   input  logic             issue_ready,
   output branch_funct3_t   issue_cmpop,
   output logic [31:0]      issue_a,
   output logic [31:0]      issue_b,
   output logic [31:0]      issue_pc,
   output logic [31:0]      issue_imm,
   output logic [TAG_W-1:0] issue_rob_tag,
   output logic             issue_pred_taken
);

   localparam int c_IDX_W = $clog2(DEPTH);
   localparam int c_CNT_W = $clog2(DEPTH + 1);

   brs_entry_t         r_entries [DEPTH];
   logic [c_CNT_W-1:0] r_count;

   brs_entry_t         w_ext     [DEPTH+1];
   brs_entry_t         w_src     [DEPTH];
   brs_entry_t         w_next    [DEPTH];
   rs_operand_t        w_cap_rs1 [DEPTH];
   rs_operand_t        w_cap_rs2 [DEPTH];

   logic               w_any_ready;
   logic [c_IDX_W-1:0] w_sel_idx;
   brs_entry_t         w_sel;
   logic               w_issue_fire;
   logic               w_disp_fire;
   logic [c_CNT_W-1:0] w_wr_idx;

   rs_operand_t        w_disp_rs1_in;
   rs_operand_t        w_disp_rs2_in;
   rs_operand_t        w_disp_rs1;
   rs_operand_t        w_disp_rs2;
   brs_entry_t         w_disp_entry;

   // ------------------------------------------------------------------
   // Select: lowest-index entry with both operands ready. Uses only the
   // registered operand state, so a capture becomes issuable next cycle.
   // ------------------------------------------------------------------
   always_comb begin
      w_any_ready = 1'b0;
      w_sel_idx   = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (r_entries[i].valid && r_entries[i].rs1.rdy && r_entries[i].rs2.rdy) begin
            w_any_ready = 1'b1;
            w_sel_idx   = c_IDX_W'(i);
         end
      end
   end

   assign w_sel = r_entries[w_sel_idx];

   assign issue_valid      = !flush && w_any_ready;
   assign issue_cmpop      = w_sel.funct3;
   assign issue_a          = w_sel.rs1.val;
   assign issue_b          = w_sel.rs2.val;
   assign issue_pc         = w_sel.pc;
   assign issue_imm        = w_sel.imm;
   assign issue_rob_tag    = w_sel.rob_tag;
   assign issue_pred_taken = w_sel.pred_taken;

   // Full is judged on the registered count alone; an issue in the same
   // cycle does not free a slot for dispatch until the next cycle.
   assign dispatch_ready = (r_count != c_CNT_W'(DEPTH)) && !flush;

   assign w_issue_fire = issue_valid && issue_ready;
   assign w_disp_fire  = dispatch_valid && dispatch_ready;

   // ------------------------------------------------------------------
   // Collapse: on issue, every slot at or above the selected one takes the
   // contents of the slot above it. The extended array supplies an empty
   // entry above the top slot.
   // ------------------------------------------------------------------
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         w_ext[i] = r_entries[i];
      end
      w_ext[DEPTH] = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (w_issue_fire && (c_IDX_W'(i) >= w_sel_idx)) begin
            w_src[i] = w_ext[i+1];
         end else begin
            w_src[i] = w_ext[i];
         end
      end
   end

   // CDB capture is applied after the shift so it lands in the slot the
   // operand will occupy next cycle.
   for (genvar g = 0; g < DEPTH; g++) begin : g_slot
      rs_operand_capture u_cap_rs1 (
         .op_in     (w_src[g].rs1),
         .cdb_valid (cdb_valid),
         .cdb_tag   (cdb_tag),
         .cdb_data  (cdb_data),
         .op_out    (w_cap_rs1[g])
      );
      rs_operand_capture u_cap_rs2 (
         .op_in     (w_src[g].rs2),
         .cdb_valid (cdb_valid),
         .cdb_tag   (cdb_tag),
         .cdb_data  (cdb_data),
         .op_out    (w_cap_rs2[g])
      );
   end

   // ------------------------------------------------------------------
   // Dispatch path, including same-cycle CDB bypass.
   // ------------------------------------------------------------------
   always_comb begin
      w_disp_rs1_in     = '0;
      w_disp_rs1_in.rdy = dispatch_rs1_rdy;
      w_disp_rs1_in.tag = dispatch_rs1_tag;
      w_disp_rs1_in.val = dispatch_rs1_val;
      w_disp_rs2_in     = '0;
      w_disp_rs2_in.rdy = dispatch_rs2_rdy;
      w_disp_rs2_in.tag = dispatch_rs2_tag;
      w_disp_rs2_in.val = dispatch_rs2_val;
   end

   rs_operand_capture u_disp_cap_rs1 (
      .op_in     (w_disp_rs1_in),
      .cdb_valid (cdb_valid),
      .cdb_tag   (cdb_tag),
      .cdb_data  (cdb_data),
      .op_out    (w_disp_rs1)
   );

   rs_operand_capture u_disp_cap_rs2 (
      .op_in     (w_disp_rs2_in),
      .cdb_valid (cdb_valid),
      .cdb_tag   (cdb_tag),
      .cdb_data  (cdb_data),
      .op_out    (w_disp_rs2)
   );

   always_comb begin
      w_disp_entry            = '0;
      w_disp_entry.valid      = 1'b1;
      w_disp_entry.funct3     = dispatch_funct3;
      w_disp_entry.rob_tag    = dispatch_rob_tag;
      w_disp_entry.pc         = dispatch_pc;
      w_disp_entry.imm        = dispatch_imm;
      w_disp_entry.pred_taken = dispatch_pred_taken;
      w_disp_entry.rs1        = w_disp_rs1;
      w_disp_entry.rs2        = w_disp_rs2;
   end

   // New entry goes to the first free slot after any collapse.
   always_comb begin
      w_wr_idx = r_count - c_CNT_W'(w_issue_fire);
      for (int i = 0; i < DEPTH; i++) begin
         w_next[i]     = w_src[i];
         w_next[i].rs1 = w_cap_rs1[i];
         w_next[i].rs2 = w_cap_rs2[i];
         if (w_disp_fire && (w_wr_idx == c_CNT_W'(i))) begin
            w_next[i] = w_disp_entry;
         end
      end
   end

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_entries[i] <= '0;
         end
         r_count <= '0;
      end else if (flush) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_entries[i].valid <= 1'b0;
         end
         r_count <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            r_entries[i] <= w_next[i];
         end
         r_count <= r_count + c_CNT_W'(w_disp_fire) - c_CNT_W'(w_issue_fire);
      end
   end

endmodule : branch_rs
`default_nettype wire

// File: tb/tb_branch_rs.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_rs
// Description : Self-checking bench for branch_rs. Expected issue records
//               are queued when branches are dispatched and popped when the
//               station presents them on the issue port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_rs;
   import rv32i_types::*;

   typedef struct packed {
      logic [2:0]  cmpop;
      logic [3:0]  rob;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] pc;
      logic [31:0] imm;
      logic        pred;
   } iss_t;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic           flush = 1'b0;
   logic           dispatch_valid = 1'b0;
   logic           dispatch_ready;
   branch_funct3_t dispatch_funct3 = BEQ;
   logic [3:0]     dispatch_rob_tag = '0;
   logic [31:0]    dispatch_pc = '0;
   logic [31:0]    dispatch_imm = '0;
   logic           dispatch_pred_taken = 1'b0;
   logic           dispatch_rs1_rdy = 1'b0;
   logic           dispatch_rs2_rdy = 1'b0;
   logic [31:0]    dispatch_rs1_val = '0;
   logic [31:0]    dispatch_rs2_val = '0;
   logic [3:0]     dispatch_rs1_tag = '0;
   logic [3:0]     dispatch_rs2_tag = '0;
   logic           cdb_valid = 1'b0;
   logic [3:0]     cdb_tag = '0;
   logic [31:0]    cdb_data = '0;
   logic           issue_valid;
   logic           issue_ready = 1'b0;
   branch_funct3_t issue_cmpop;
   logic [31:0]    issue_a;
   logic [31:0]    issue_b;
   logic [31:0]    issue_pc;
   logic [31:0]    issue_imm;
   logic [3:0]     issue_rob_tag;
   logic           issue_pred_taken;

   int   n_tests = 0;
   int   n_fail  = 0;
   iss_t exp_q[$];
   iss_t got;
   iss_t exp;

   branch_rs #(.DEPTH(4), .TAG_W(4)) u_dut (
      .clk                 (clk),
      .rst                 (rst),
      .flush               (flush),
      .dispatch_valid      (dispatch_valid),
      .dispatch_ready      (dispatch_ready),
      .dispatch_funct3     (dispatch_funct3),
      .dispatch_rob_tag    (dispatch_rob_tag),
      .dispatch_pc         (dispatch_pc),
      .dispatch_imm        (dispatch_imm),
      .dispatch_pred_taken (dispatch_pred_taken),
      .dispatch_rs1_rdy    (dispatch_rs1_rdy),
      .dispatch_rs2_rdy    (dispatch_rs2_rdy),
      .dispatch_rs1_val    (dispatch_rs1_val),
      .dispatch_rs2_val    (dispatch_rs2_val),
      .dispatch_rs1_tag    (dispatch_rs1_tag),
      .dispatch_rs2_tag    (dispatch_rs2_tag),
      .cdb_valid           (cdb_valid),
      .cdb_tag             (cdb_tag),
      .cdb_data            (cdb_data),
      .issue_valid         (issue_valid),
      .issue_ready         (issue_ready),
      .issue_cmpop         (issue_cmpop),
      .issue_a             (issue_a),
      .issue_b             (issue_b),
      .issue_pc            (issue_pc),
      .issue_imm           (issue_imm),
      .issue_rob_tag       (issue_rob_tag),
      .issue_pred_taken    (issue_pred_taken)
   );

   always #5 clk = ~clk;

   // Advance one cycle; lands on the falling edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_dispatch(input branch_funct3_t f, input logic [3:0] rob,
                               input logic [31:0] pc, input logic [31:0] imm,
                               input logic pred,
                               input logic r1rdy, input logic [3:0] r1tag,
                               input logic [31:0] r1val,
                               input logic r2rdy, input logic [3:0] r2tag,
                               input logic [31:0] r2val);
      dispatch_valid      = 1'b1;
      dispatch_funct3     = f;
      dispatch_rob_tag    = rob;
      dispatch_pc         = pc;
      dispatch_imm        = imm;
      dispatch_pred_taken = pred;
      dispatch_rs1_rdy    = r1rdy;
      dispatch_rs1_tag    = r1tag;
      dispatch_rs1_val    = r1val;
      dispatch_rs2_rdy    = r2rdy;
      dispatch_rs2_tag    = r2tag;
      dispatch_rs2_val    = r2val;
   endtask

   function automatic iss_t mk_exp(input branch_funct3_t f, input logic [3:0] rob,
                                   input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] pc, input logic [31:0] imm,
                                   input logic pred);
      iss_t e;
      e.cmpop = f;
      e.rob   = rob;
      e.a     = a;
      e.b     = b;
      e.pc    = pc;
      e.imm   = imm;
      e.pred  = pred;
      return e;
   endfunction

   function automatic iss_t dut_issue();
      iss_t g;
      g.cmpop = issue_cmpop;
      g.rob   = issue_rob_tag;
      g.a     = issue_a;
      g.b     = issue_b;
      g.pc    = issue_pc;
      g.imm   = issue_imm;
      g.pred  = issue_pred_taken;
      return g;
   endfunction

   // ------------------------------------------------------------------
   task automatic test_reset();
      n_tests++;
      if (issue_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_issue_valid: got %b expected 0", issue_valid);
      end
      n_tests++;
      if (dispatch_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_dispatch_ready: got %b expected 1", dispatch_ready);
      end
      rst = 1'b1;
      step();
      // Three entries each waiting on rs1 tag 1..3.
      for (int k = 0; k < 3; k++) begin
         set_dispatch(BEQ, 4'(k + 1), 32'h100, 32'h4, 1'b0,
                      1'b0, 4'(k + 1), 32'h0, 1'b1, 4'h0, 32'h0);
         #1;
         n_tests++;
         if (dispatch_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_prefill_ready: got %b expected 1", dispatch_ready);
         end
         step();
         dispatch_valid = 1'b0;
      end
      // Asynchronous reset in the middle of the cycle.
      #1 rst = 1'b0;
      #1;
      n_tests++;
      if (issue_valid !== 1'b0) begin
         n_fail++; $display("FAIL midreset_issue_valid: got %b expected 0", issue_valid);
      end
      n_tests++;
      if (dispatch_ready !== 1'b1) begin
         n_fail++; $display("FAIL midreset_dispatch_ready: got %b expected 1", dispatch_ready);
      end
      step();
      rst = 1'b1;
      // Waking the old tags must produce nothing: the entries are gone.
      cdb_valid = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         cdb_tag = 4'(k);
         step();
      end
      cdb_valid = 1'b0;
      #1;
      n_tests++;
      if (issue_valid !== 1'b0) begin
         n_fail++; $display("FAIL midreset_entries_cleared: got %b expected 0", issue_valid);
      end
      // Count restarted at zero: exactly four entries fit.
      for (int k = 0; k < 4; k++) begin
         set_dispatch(BNE, 4'(k), 32'h200, 32'h8, 1'b0,
                      1'b0, 4'hF, 32'h0, 1'b0, 4'hF, 32'h0);
         #1;
         n_tests++;
         if (dispatch_ready !== 1'b1) begin
            n_fail++; $display("FAIL midreset_count_fill: got %b expected 1 at %0d", dispatch_ready, k);
         end
         step();
         dispatch_valid = 1'b0;
      end
      #1;
      n_tests++;
      if (dispatch_ready !== 1'b0) begin
         n_fail++; $display("FAIL midreset_count_full: got %b expected 0", dispatch_ready);
      end
      flush = 1'b1;
      step();
      flush = 1'b0;
   endtask

   // ------------------------------------------------------------------
   task automatic test_beq_ready();
      issue_ready = 1'b1;
      set_dispatch(BEQ, 4'd1, 32'h1000, 32'h10, 1'b1, 1'b1, 4'h0, 32'd5, 1'b1, 4'h0, 32'd5);
      exp_q.push_back(mk_exp(BEQ, 4'd1, 32'd5, 32'd5, 32'h1000, 32'h10, 1'b1));
      #1;
      n_tests++;
      if (issue_valid !== 1'b0) begin
         n_fail++; $display("FAIL beq_same_cycle: got issue_valid %b expected 0", issue_valid);
      end
      step();
      dispatch_valid = 1'b0;
      #1;
      n_tests++;
      if (issue_valid !== 1'b1) begin
         n_fail++; $display("FAIL beq_issue_valid: got %b expected 1", issue_valid);
      end else begin
         got = dut_issue();
         exp = exp_q.pop_front();
         n_tests++;
         if (got !== exp) begin
            n_fail++; $display("FAIL beq_fields: got %h expected %h", got, exp);
         end
      end
      step();
      #1;
      n_tests++;
      if (issue_valid !== 1'b0) begin
         n_fail++; $display("FAIL beq_drained: got %b expected 0", issue_valid);
      end
   endtask

   // ------------------------------------------------------------------
   task automatic test_cdb_wakeup();
      issue_ready = 1'b1;
      set_dispatch(BLT, 4'd2, 32'h2000, 32'hFFFF_FFFC, 1'b0,
                   1'b1, 4'h0, 32'hFFFF_FFFF, 1'b0, 4'd3, 32'hDEAD_BEEF);
      exp_q.push_back(mk_exp(BLT, 4'd2, 32'hFFFF_FFFF, 32'd7, 32'h2000, 32'hFFFF_FFFC, 1'b0));
      step();
      dispatch_valid = 1'b0;
      #1;
      n_tests++;
      if (issue_valid !== 1'b0) begin
         n_fail++; $display("FAIL wakeup_early_c2: got %b expected 0", issue_valid);
      end
      cdb_valid = 1'b1;
      cdb_tag   = 4'd3;
      cdb_data  = 32'd7;
      #1;
      n_tests++;
      if (issue_valid !== 1'b0) begin
         n_fail++; $display("FAIL wakeup_no_forward: got %b expected 0", issue_valid);
      end
      step();
      cdb_valid = 1'b0;
      #1;
      n_tests++;
      if (issue_valid !== 1'b1) begin
         n_fail++; $display("FAIL wakeup_c3_valid: got %b expected 1", issue_valid);
      end else begin
         got = dut_issue();
         exp = exp_q.pop_front();
         n_tests++;
         if (got !== exp) begin
            n_fail++; $display("FAIL wakeup_fields: got %h expected %h", got, exp);
         end
      end
      step();
   endtask

   // ------------------------------------------------------------------
   task automatic test_bypass();
      issue_ready = 1'b1;
      set_dispatch(BNE, 4'd5, 32'h3000, 32'h20, 1'b1,
                   1'b0, 4'd9, 32'h0000_DEAD, 1'b1, 4'h0, 32'h20);
      cdb_valid = 1'b1;
      cdb_tag   = 4'd9;
      cdb_data  = 32'h100;
      exp_q.push_back(mk_exp(BNE, 4'd5, 32'h100, 32'h20, 32'h3000, 32'h20, 1'b1));
      step();
      dispatch_valid = 1'b0;
      cdb_valid      = 1'b0;
      #1;
      n_tests++;
      if (issue_valid !== 1'b1) begin
         n_fail++; $display("FAIL bypass_valid: got %b expected 1", issue_valid);
      end else begin
         got = dut_issue();
         exp = exp_q.pop_front();
         n_tests++;
         if (got !== exp) begin
            n_fail++; $display("FAIL bypass_fields: got %h expected %h", got, exp);
         end
      end
      step();
   endtask

   // ------------------------------------------------------------------
   task automatic test_full_stall();
      issue_ready = 1'b0;
      // Issue order: rob12 (ready), rob13 (tag5), rob10 (tag1), rob11 (tag2).
      exp_q.push_back(mk_exp(BGEU, 4'd12, 32'hC, 32'hC0, 32'h5008, 32'h18, 1'b1));
      exp_q.push_back(mk_exp(BEQ,  4'd13, 32'hD, 32'h55, 32'h500C, 32'h1C, 1'b0));
      exp_q.push_back(mk_exp(BGE,  4'd10, 32'h11, 32'hA0, 32'h5000, 32'h10, 1'b0));
      exp_q.push_back(mk_exp(BLTU, 4'd11, 32'hB, 32'h22, 32'h5004, 32'h14, 1'b1));
      set_dispatch(BGE,  4'd10, 32'h5000, 32'h10, 1'b0, 1'b0, 4'd1, 32'h0, 1'b1, 4'h0, 32'hA0);
      step();
      set_dispatch(BLTU, 4'd11, 32'h5004, 32'h14, 1'b1, 1'b1, 4'h0, 32'hB, 1'b0, 4'd2, 32'h0);
      step();
      set_dispatch(BGEU, 4'd12, 32'h5008, 32'h18, 1'b1, 1'b1, 4'h0, 32'hC, 1'b1, 4'h0, 32'hC0);
      step();
      set_dispatch(BEQ,  4'd13, 32'h500C, 32'h1C, 1'b0, 1'b1, 4'h0, 32'hD, 1'b0, 4'd5, 32'h0);
      step();
      dispatch_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         got = dut_issue();
         n_tests++;
         if (issue_valid !== 1'b1 || got !== exp_q[0]) begin
            n_fail++; $display("FAIL stall_hold: got v=%b %h expected v=1 %h", issue_valid, got, exp_q[0]);
         end
         n_tests++;
         if (dispatch_ready !== 1'b0) begin
            n_fail++; $display("FAIL stall_full: got %b expected 0", dispatch_ready);
         end
         step();
      end
      // Release: issue rob12 while offering a dispatch that must be refused,
      // and broadcast tag 5 so rob13 captures into its shifted slot.
      issue_ready = 1'b1;
      set_dispatch(BNE, 4'd14, 32'h6000, 32'h0, 1'b0, 1'b1, 4'h0, 32'h1, 1'b1, 4'h0, 32'h1);
      cdb_valid = 1'b1;
      cdb_tag   = 4'd5;
      cdb_data  = 32'h55;
      #1;
      n_tests++;
      if (dispatch_ready !== 1'b0) begin
         n_fail++; $display("FAIL full_issue_no_credit: got %b expected 0", dispatch_ready);
      end
      got = dut_issue();
      exp = exp_q.pop_front();
      n_tests++;
      if (issue_valid !== 1'b1 || got !== exp) begin
         n_fail++; $display("FAIL stall_release: got v=%b %h expected v=1 %h", issue_valid, got, exp);
      end
      step();
      dispatch_valid = 1'b0;
      cdb_valid      = 1'b0;
      #1;
      n_tests++;
      if (dispatch_ready !== 1'b1) begin
         n_fail++; $display("FAIL after_issue_ready: got %b expected 1", dispatch_ready);
      end
      got = dut_issue();
      exp = exp_q.pop_front();
      n_tests++;
      if (issue_valid !== 1'b1 || got !== exp) begin
         n_fail++; $display("FAIL shift_capture: got v=%b %h expected v=1 %h", issue_valid, got, exp);
      end
      step();
      #1;
      n_tests++;
      if (issue_valid !== 1'b0) begin
         n_fail++; $display("FAIL waiting_not_ready: got %b expected 0", issue_valid);
      end
      cdb_valid = 1'b1;
      cdb_tag   = 4'd1;
      cdb_data  = 32'h11;
      step();
      cdb_tag  = 4'd2;
      cdb_data = 32'h22;
      #1;
      got = dut_issue();
      exp = exp_q.pop_front();
      n_tests++;
      if (issue_valid !== 1'b1 || got !== exp) begin
         n_fail++; $display("FAIL drain_rob10: got v=%b %h expected v=1 %h", issue_valid, got, exp);
      end
      step();
      cdb_valid = 1'b0;
      #1;
      got = dut_issue();
      exp = exp_q.pop_front();
      n_tests++;
      if (issue_valid !== 1'b1 || got !== exp) begin
         n_fail++; $display("FAIL drain_rob11: got v=%b %h expected v=1 %h", issue_valid, got, exp);
      end
      step();
      #1;
      n_tests++;
      if (issue_valid !== 1'b0) begin
         n_fail++; $display("FAIL full_drained: got %b expected 0", issue_valid);
      end
   endtask

   // ------------------------------------------------------------------
   task automatic test_flush_order();
      issue_ready = 1'b0;
      set_dispatch(BLT, 4'd4, 32'h7000, 32'h40, 1'b0, 1'b1, 4'h0, 32'h1, 1'b1, 4'h0, 32'h2);
      step();
      set_dispatch(BGE, 4'd6, 32'h7004, 32'h44, 1'b1, 1'b1, 4'h0, 32'h3, 1'b1, 4'h0, 32'h4);
      step();
      // Flush with a ready branch offered and a CDB broadcast in flight.
      flush       = 1'b1;
      issue_ready = 1'b1;
      set_dispatch(BEQ, 4'd7, 32'h7008, 32'h48, 1'b0, 1'b1, 4'h0, 32'h5, 1'b1, 4'h0, 32'h5);
      cdb_valid = 1'b1;
      cdb_tag   = 4'd8;
      #1;
      n_tests++;
      if (issue_valid !== 1'b0) begin
         n_fail++; $display("FAIL flush_issue_valid: got %b expected 0", issue_valid);
      end
      n_tests++;
      if (dispatch_ready !== 1'b0) begin
         n_fail++; $display("FAIL flush_dispatch_ready: got %b expected 0", dispatch_ready);
      end
      step();
      flush          = 1'b0;
      dispatch_valid = 1'b0;
      cdb_valid      = 1'b0;
      #1;
      n_tests++;
      if (issue_valid !== 1'b0) begin
         n_fail++; $display("FAIL flush_empty: got %b expected 0", issue_valid);
      end
      n_tests++;
      if (dispatch_ready !== 1'b1) begin
         n_fail++; $display("FAIL flush_ready_after: got %b expected 1", dispatch_ready);
      end
      // Same two entries without flush: age order decides.
      issue_ready = 1'b0;
      set_dispatch(BLT, 4'd4, 32'h7000, 32'h40, 1'b0, 1'b1, 4'h0, 32'h1, 1'b1, 4'h0, 32'h2);
      exp_q.push_back(mk_exp(BLT, 4'd4, 32'h1, 32'h2, 32'h7000, 32'h40, 1'b0));
      step();
      set_dispatch(BGE, 4'd6, 32'h7004, 32'h44, 1'b1, 1'b1, 4'h0, 32'h3, 1'b1, 4'h0, 32'h4);
      exp_q.push_back(mk_exp(BGE, 4'd6, 32'h3, 32'h4, 32'h7004, 32'h44, 1'b1));
      step();
      dispatch_valid = 1'b0;
      issue_ready    = 1'b1;
      for (int k = 0; k < 2; k++) begin
         #1;
         got = dut_issue();
         exp = exp_q.pop_front();
         n_tests++;
         if (issue_valid !== 1'b1 || got !== exp) begin
            n_fail++; $display("FAIL age_order: got v=%b %h expected v=1 %h", issue_valid, got, exp);
         end
         step();
      end
   endtask

   // ------------------------------------------------------------------
   task automatic test_back_to_back();
      branch_funct3_t f;
      logic [31:0]    a;
      logic [31:0]    b;
      issue_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         f = (k % 2 == 1) ? BNE : BGEU;
         a = $urandom;
         b = $urandom;
         set_dispatch(f, 4'(k), 32'h8000 + 32'(k * 4), 32'(k), k[0],
                      1'b1, 4'h0, a, 1'b1, 4'h0, b);
         exp_q.push_back(mk_exp(f, 4'(k), a, b, 32'h8000 + 32'(k * 4), 32'(k), k[0]));
         #1;
         n_tests++;
         if (dispatch_ready !== 1'b1) begin
            n_fail++; $display("FAIL b2b_ready: got %b expected 1 at %0d", dispatch_ready, k);
         end
         if (k > 0) begin
            got = dut_issue();
            exp = exp_q.pop_front();
            n_tests++;
            if (issue_valid !== 1'b1 || got !== exp) begin
               n_fail++; $display("FAIL b2b_issue: got v=%b %h expected v=1 %h", issue_valid, got, exp);
            end
         end
         step();
      end
      dispatch_valid = 1'b0;
      #1;
      got = dut_issue();
      exp = exp_q.pop_front();
      n_tests++;
      if (issue_valid !== 1'b1 || got !== exp) begin
         n_fail++; $display("FAIL b2b_last: got v=%b %h expected v=1 %h", issue_valid, got, exp);
      end
      step();
      #1;
      n_tests++;
      if (issue_valid !== 1'b0 || exp_q.size() != 0) begin
         n_fail++; $display("FAIL b2b_empty: got v=%b left=%0d expected v=0 left=0", issue_valid, exp_q.size());
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_beq_ready();
      test_cdb_wakeup();
      test_bypass();
      test_full_stall();
      test_flush_order();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_branch_rs
`default_nettype wire
